// File: rtl/rtc_shadow_regs.sv
// Shadow register block between the host bus and the PCF8563 controller.
// Polls the chip, accepts only repeated valid BCD snapshots and stages host set requests.
module rtc_shadow_regs #(
   parameter int unsigned POLL_CYCLES   = 2800000,
   parameter int unsigned REQ_HOLD      = 64,
   parameter int unsigned SETTLE_CYCLES = 4096,
   parameter int unsigned MATCH_COUNT   = 2
) (
   input  logic        mclk,
   input  logic        reset,
   input  logic [55:0] rtc_raw,
   output logic        rtc_get,
   output logic        rtc_set,
   output logic [55:0] rtc_in,
   input  logic [2:0]  host_addr,
   input  logic [7:0]  host_din,
   input  logic        host_we,
   input  logic        host_commit,
   output logic [7:0]  host_dout,
   output logic        busy,
   output logic        time_valid,
   output logic [63:0] rtc_time
);

   localparam int unsigned PW   = $clog2(POLL_CYCLES + 1);
   localparam int unsigned CMAX = (SETTLE_CYCLES > REQ_HOLD) ? SETTLE_CYCLES : REQ_HOLD;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned MW   = $clog2(MATCH_COUNT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_REQ, S_WAIT, S_CHECK, S_SET_REQ, S_SET_WAIT
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_poll;
   logic [CW-1:0]   r_cnt;
   logic [MW-1:0]   r_match;
   logic [55:0]     r_stg;
   logic            r_pend;
   logic [57:0]     r_prev;
   logic [55:0]     r_shadow;
   logic            r_vl;
   logic            r_century;
   logic            r_bcd_err;
   logic            r_get;
   logic            r_set;
   logic [55:0]     r_in;
   logic            r_busy;
   logic            r_tv;

   logic [55:0]     w_stg_next;
   logic            w_commit;
   logic [7:0]      w_sec, w_min, w_hour, w_day, w_wday, w_mon, w_year;
   logic [57:0]     w_clean;
   logic            w_valid;
   logic [MW-1:0]   w_match_next;

   function automatic logic f_ok(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
   endfunction

   // Staging view including this cycle's write, so a same-cycle commit sends the new byte
   always_comb begin
      w_stg_next = r_stg;
      for (int unsigned i = 0; i < 7; i++) begin
         if (host_we && !r_busy && host_addr == 3'(i))
            w_stg_next[8*(6-i) +: 8] = host_din;
      end
   end

   assign w_commit = host_commit && !r_busy;

   assign w_sec  = {1'b0, rtc_raw[54:48]};
   assign w_min  = {1'b0, rtc_raw[46:40]};
   assign w_hour = {2'b0, rtc_raw[37:32]};
   assign w_day  = {2'b0, rtc_raw[29:24]};
   assign w_wday = {5'b0, rtc_raw[18:16]};
   assign w_mon  = {3'b0, rtc_raw[12:8]};
   assign w_year = rtc_raw[7:0];

   assign w_clean = {rtc_raw[55], rtc_raw[15], w_sec, w_min, w_hour, w_day, w_wday, w_mon, w_year};

   assign w_valid = f_ok(w_sec, 8'h00, 8'h59) && f_ok(w_min, 8'h00, 8'h59) &&
                    f_ok(w_hour, 8'h00, 8'h23) && f_ok(w_day, 8'h01, 8'h31) &&
                    f_ok(w_wday, 8'h00, 8'h06) && f_ok(w_mon, 8'h01, 8'h12) &&
                    f_ok(w_year, 8'h00, 8'h99);

   always_comb begin
      w_match_next = MW'(1);
      if (w_clean == r_prev && r_match != '0)
         w_match_next = (r_match >= MW'(MATCH_COUNT)) ? r_match : r_match + 1'b1;
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_poll    <= '0;
         r_cnt     <= '0;
         r_match   <= '0;
         r_stg     <= '0;
         r_pend    <= 1'b0;
         r_prev    <= '0;
         r_shadow  <= '0;
         r_vl      <= 1'b0;
         r_century <= 1'b0;
         r_bcd_err <= 1'b0;
         r_get     <= 1'b0;
         r_set     <= 1'b0;
         r_in      <= '0;
         r_busy    <= 1'b0;
         r_tv      <= 1'b0;
      end else begin
         r_stg <= w_stg_next;
         if (w_commit) r_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_commit || r_pend) begin
                  r_pend  <= 1'b0;
                  r_in    <= w_stg_next;
                  r_set   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_SET_REQ;
               end else if (r_poll == PW'(POLL_CYCLES - 1)) begin
                  r_poll  <= '0;
                  r_get   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_GET_REQ;
               end else begin
                  r_poll <= r_poll + 1'b1;
               end
            end
            S_GET_REQ: begin
               if (r_cnt == CW'(REQ_HOLD - 1)) begin
                  r_get   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_CHECK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (!w_valid) begin
                  r_bcd_err <= 1'b1;
                  r_match   <= '0;
               end else begin
                  r_prev  <= w_clean;
                  r_match <= w_match_next;
                  if (w_match_next >= MW'(MATCH_COUNT)) begin
                     r_shadow  <= w_clean[55:0];
                     r_vl      <= w_clean[57];
                     r_century <= w_clean[56];
                     r_tv      <= 1'b1;
                     r_bcd_err <= 1'b0;
                  end
               end
               r_state <= S_IDLE;
            end
            S_SET_REQ: begin
               if (r_cnt == CW'(REQ_HOLD - 1)) begin
                  r_set   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SET_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SET_WAIT: begin
               if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  r_busy  <= 1'b0;
                  r_match <= '0;
                  r_tv    <= 1'b0;
                  r_cnt   <= '0;
                  r_poll  <= PW'(POLL_CYCLES - 1);
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      host_dout = {r_busy, r_tv, r_vl, r_bcd_err, 4'b0};
      for (int unsigned i = 0; i < 7; i++) begin
         if (host_addr == 3'(i))
            host_dout = r_shadow[8*(6-i) +: 8];
      end
   end

   assign rtc_get    = r_get;
   assign rtc_set    = r_set;
   assign rtc_in     = r_in;
   assign busy       = r_busy;
   assign time_valid = r_tv;
   assign rtc_time   = {r_century, r_vl, 6'b0, r_shadow[23:16], r_shadow[7:0], r_shadow[15:8],
                        r_shadow[31:24], r_shadow[39:32], r_shadow[47:40], r_shadow[55:48]};

endmodule

// File: tb/tb_rtc_shadow_regs.sv
// Directed bench for rtc_shadow_regs with short poll/hold/settle periods.
module tb_rtc_shadow_regs;

   localparam int unsigned P  = 100;
   localparam int unsigned RH = 4;
   localparam int unsigned SC = 8;

   localparam logic [55:0] T1_RAW  = 56'h00_59_23_31_06_12_99;
   localparam logic [63:0] T1_TIME = 64'h00_06_99_12_31_23_59_00;
   localparam logic [55:0] T2_RAW  = 56'h85_59_23_31_06_81_99;
   localparam logic [63:0] T2_TIME = 64'hC0_06_99_01_31_23_59_05;
   localparam logic [55:0] SET_VAL = 56'h30_15_08_04_02_07_24;

   logic        mclk = 1'b0;
   logic        reset = 1'b0;
   logic [55:0] rtc_raw = '0;
   logic        rtc_get, rtc_set, busy, time_valid;
   logic [55:0] rtc_in;
   logic [2:0]  host_addr = 3'd7;
   logic [7:0]  host_din = '0;
   logic        host_we = 1'b0;
   logic        host_commit = 1'b0;
   logic [7:0]  host_dout;
   logic [63:0] rtc_time;

   int n_checks = 0;
   int n_errors = 0;

   rtc_shadow_regs #(
      .POLL_CYCLES(P), .REQ_HOLD(RH), .SETTLE_CYCLES(SC), .MATCH_COUNT(2)
   ) dut (
      .mclk(mclk), .reset(reset), .rtc_raw(rtc_raw), .rtc_get(rtc_get), .rtc_set(rtc_set),
      .rtc_in(rtc_in), .host_addr(host_addr), .host_din(host_din), .host_we(host_we),
      .host_commit(host_commit), .host_dout(host_dout), .busy(busy),
      .time_valid(time_valid), .rtc_time(rtc_time)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_poll();
      int n;
      n = 0;
      while (!rtc_get && n < 1000) begin @(negedge mclk); n++; end
      if (!rtc_get) check("poll_start_timeout", 64'd0, 64'd1);
      n = 0;
      while (rtc_get && n < 1000) begin @(negedge mclk); n++; end
      if (rtc_get) check("poll_end_timeout", 64'd1, 64'd0);
      repeat (SC + 3) @(negedge mclk);
   endtask

   task automatic chk_status(input string tag, input logic [7:0] exp);
      host_addr = 3'd7;
      #1 check(tag, {56'd0, host_dout}, {56'd0, exp});
   endtask

   initial begin
      int n;
      logic [7:0] wr [7];
      wr = '{8'h30, 8'h15, 8'h08, 8'h04, 8'h02, 8'h07, 8'h24};

      #1;
      check("rst_get", {63'd0, rtc_get}, 64'd0);
      check("rst_set", {63'd0, rtc_set}, 64'd0);
      check("rst_in", {8'd0, rtc_in}, 64'd0);
      check("rst_busy_tv", {62'd0, busy, time_valid}, 64'd0);
      check("rst_time", rtc_time, 64'd0);
      chk_status("rst_status", 8'h00);

      rtc_raw = T1_RAW;
      @(negedge mclk) reset = 1'b1;

      // stable time: one poll is not enough, the second publishes
      wait_poll();
      check("t1_one_match_tv", {63'd0, time_valid}, 64'd0);
      wait_poll();
      check("t1_tv", {63'd0, time_valid}, 64'd1);
      check("t1_time", rtc_time, T1_TIME);
      host_addr = 3'd1;
      #1 check("t1_dout_min", {56'd0, host_dout}, 64'h59);
      chk_status("t1_status", 8'h40);

      // VL / century bits
      rtc_raw = T2_RAW;
      wait_poll();
      check("t2_first_time", rtc_time, T1_TIME);
      wait_poll();
      check("t2_time", rtc_time, T2_TIME);
      chk_status("t2_status", 8'h60);

      // invalid BCD nibble
      rtc_raw = 56'h85_6A_23_31_06_81_99;
      wait_poll();
      check("t3_bad_time", rtc_time, T2_TIME);
      chk_status("t3_bad_status", 8'h70);
      rtc_raw = T1_RAW;
      wait_poll();
      chk_status("t3_one_match_status", 8'h70);
      wait_poll();
      check("t3_recover_time", rtc_time, T1_TIME);
      chk_status("t3_recover_status", 8'h40);

      // out-of-range hour
      rtc_raw = 56'h00_59_24_31_06_12_99;
      wait_poll();
      check("hr24_time", rtc_time, T1_TIME);
      chk_status("hr24_status", 8'h50);

      // alternating seconds never reach two matches
      for (int unsigned i = 0; i < 4; i++) begin
         rtc_raw = (i % 2 == 0) ? 56'h10_59_23_31_06_12_99 : 56'h11_59_23_31_06_12_99;
         wait_poll();
         check("toggle_time", rtc_time, T1_TIME);
         chk_status("toggle_status", 8'h50);
      end

      // staging writes, commit in the same cycle as the final byte
      for (int unsigned i = 0; i < 7; i++) begin
         @(negedge mclk);
         host_we = 1'b1; host_addr = 3'(i); host_din = wr[i];
         host_commit = (i == 6);
      end
      @(negedge mclk);
      host_we = 1'b0; host_commit = 1'b0;
      check("set_rtc_in", {8'd0, rtc_in}, {8'd0, SET_VAL});
      check("set_get_low", {63'd0, rtc_get}, 64'd0);
      chk_status("set_status_busy", 8'hD0);
      n = 0;
      while (rtc_set && n < 100) begin
         n++;
         if (n == 2) begin
            host_we = 1'b1; host_addr = 3'd0; host_din = 8'hFF; host_commit = 1'b1;
         end else begin
            host_we = 1'b0; host_commit = 1'b0;
         end
         @(negedge mclk);
      end
      host_we = 1'b0; host_commit = 1'b0;
      check("set_hold_cycles", 64'(n), 64'(RH));
      check("set_wait_busy", {63'd0, busy}, 64'd1);
      n = 0;
      while (busy && n < 100) begin @(negedge mclk); n++; end
      check("set_busy_cycles", 64'(n), 64'(SC));
      check("set_end_tv", {63'd0, time_valid}, 64'd0);
      check("set_end_get", {63'd0, rtc_get}, 64'd0);
      chk_status("set_end_status", 8'h10);
      @(negedge mclk);
      check("set_next_get", {63'd0, rtc_get}, 64'd1);

      // commit during GET_REQ is held until IDLE; staging kept despite busy write
      host_commit = 1'b1;
      @(negedge mclk) host_commit = 1'b0;
      n = 0;
      while (!rtc_set && n < 100) begin @(negedge mclk); n++; end
      check("pend_set_seen", {63'd0, rtc_set}, 64'd1);
      check("pend_get_low", {63'd0, rtc_get}, 64'd0);
      check("pend_rtc_in", {8'd0, rtc_in}, {8'd0, SET_VAL});
      n = 0;
      while (busy && n < 100) begin @(negedge mclk); n++; end
      check("pend_busy_clear", {63'd0, busy}, 64'd0);

      // asynchronous reset during GET_REQ
      n = 0;
      while (!rtc_get && n < 100) begin @(negedge mclk); n++; end
      check("rst6_get_seen", {63'd0, rtc_get}, 64'd1);
      #2 reset = 1'b0;
      #1;
      check("rst6_get", {63'd0, rtc_get}, 64'd0);
      check("rst6_busy_tv", {62'd0, busy, time_valid}, 64'd0);
      check("rst6_in", {8'd0, rtc_in}, 64'd0);
      @(negedge mclk) reset = 1'b1;
      n = 0;
      while (!rtc_get && n < 300) begin @(negedge mclk); n++; end
      check("rst6_first_get", 64'(n), 64'(P));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   always @(negedge mclk) begin
      if (reset && rtc_get && rtc_set) check("get_set_overlap", 64'd1, 64'd0);
   end

endmodule

// File: doc/rtc_shadow_regs.md
Name: rtc_shadow_regs

Overview:
- Sits between the host/menu register bus and the PCF8563 I2C controller.
- Periodically requests reads and accepts a time snapshot only after consecutive samples agree and pass BCD validation.
- Sanitises the raw chip fields and publishes a stable 64-bit time word; stages host time writes and commits them as a set request.
- Drives the controller's rtc_get, rtc_set and rtc_in; consumes its rtc output, here called rtc_raw.

Parameters:
- POLL_CYCLES, 2800000: mclk cycles between read requests (about 100 ms at 28 MHz).
- REQ_HOLD, 64: mclk cycles a request line stays high; covers the controller's divided clock.
- SETTLE_CYCLES, 4096: mclk cycles after a request before rtc_raw is sampled.
- MATCH_COUNT, 2: consecutive identical valid samples needed before the shadow updates.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rtc_raw  in  56  controller readback {sec,min,hour,day,weekday,month,year}, sec in [55:48].
- rtc_get  out  1  read request level to controller.
- rtc_set  out  1  write request level to controller.
- rtc_in  out  56  write data to controller, same byte order as rtc_raw.
- host_addr  in  3  byte select: 0 sec, 1 min, 2 hour, 3 day, 4 weekday, 5 month, 6 year, 7 status.
- host_din  in  8  staging write data.
- host_we  in  1  one-cycle staging byte write; ignored at addr 7.
- host_commit  in  1  one-cycle pulse: send the staging bytes to the chip.
- host_dout  out  8  combinational readback.
- busy  out  1  a set is in progress.
- time_valid  out  1  shadow holds accepted chip time.
- rtc_time  out  64  published time word.

Behaviour:
- Reset (reset=0, asynchronous):
  - rtc_get=0, rtc_set=0, rtc_in=0, busy=0, time_valid=0, rtc_time=0.
  - Staging=0, match counter=0, poll counter=0, FSM=IDLE, bcd_err=0.
- FSM states:
  - IDLE: poll counter counts to POLL_CYCLES-1. A commit has priority: go to SET_REQ. Otherwise go to GET_REQ when the counter wraps.
  - GET_REQ: rtc_get=1 for REQ_HOLD cycles, then WAIT.
  - WAIT: count SETTLE_CYCLES, then CHECK.
  - CHECK (one cycle): sanitise and validate rtc_raw, then back to IDLE.
  - SET_REQ: latch staging into rtc_in on entry; rtc_set=1 for REQ_HOLD cycles; busy=1. Then SET_WAIT.
  - SET_WAIT: SETTLE_CYCLES with busy=1. Then clear the match counter and time_valid, and go to IDLE with the poll counter forced to wrap next cycle.
- Sanitising masks applied in CHECK:
  - sec&7F, with vl=sec[7]
  - min&7F
  - hour&3F
  - day&3F
  - weekday&07
  - month&1F, with century=month[7]
  - year unmasked
- Validation:
  - Every nibble must be ≤9.
  - Ranges: sec≤59, min≤59, hour≤23, day 1..31, month 1..12, weekday≤6.
  - Failure: bcd_err=1, match counter=0, sample discarded, shadow unchanged.
- Matching:
  - A valid sample equal to the previous valid sample increments the match counter (saturating); otherwise the counter is set to 1.
  - When the counter reaches MATCH_COUNT, the shadow loads the sample, time_valid=1 and bcd_err=0.
- rtc_time layout:
  - [7:0] sec, [15:8] min, [23:16] hour, [31:24] day, [39:32] month, [47:40] year, [55:48] weekday.
  - [63:56] = {century, vl, 6'b0}.
- host_dout:
  - addr 0..6 returns the shadow byte.
  - addr 7 returns {busy, time_valid, vl, bcd_err, 4'b0}.
- Host writes and commits:
  - host_we updates the staging byte unless busy=1, in which case it is ignored.
  - host_commit while busy is ignored.
  - host_commit during GET_REQ/WAIT/CHECK is held pending and taken at the next IDLE.
  - A commit in the same cycle as host_we takes the just-written byte.
- rtc_get and rtc_set are never high together.
- Counter wrap: the poll counter wraps to 0 at POLL_CYCLES-1.
- Reset mid-operation: all request lines drop immediately; no partial set is retried.

Test Plan:
1. Stable time: POLL_CYCLES=100, rtc_raw=00_59_23_31_06_12_99 with sec byte 0x00 → after 2 polls, time_valid=1, rtc_time[55:0]=06_99_12_31_23_59_00.
2. VL/century bits: rtc_raw sec=0x85, month=0x81 (rest valid) → rtc_time[7:0]=05, [39:32]=01, [63:56]=0xC0, addr7 bit5=1.
3. Invalid BCD: min=0x6A → bcd_err=1, shadow unchanged, time_valid keeps its previous value. Then valid data → bcd_err clears after 2 matches.
4. Changing data: rtc_raw sec toggles 10/11 each poll → shadow never updates, match counter never reaches 2.
5. Set: write staging 0x30,0x15,0x08,0x04,0x02,0x07,0x24, then commit → rtc_in=30_15_08_04_02_07_24 and rtc_set high for exactly REQ_HOLD cycles. busy=1 until SET_WAIT ends; time_valid drops to 0 and a GET_REQ starts the next cycle. host_we while busy leaves staging unchanged.
6. Asynchronous reset asserted during GET_REQ → rtc_get=0 with no clock edge. After release, IDLE, and the first get occurs POLL_CYCLES cycles later.
